// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It detects load-use
// hazards and applies taken-branch flushes. It also runs the req/ready
// handshake with variable-latency data memory, guarded by a wait-timeout
// watchdog.
// Optional feature: define HAZARD_PERF_CNT_EN to build the three saturating
// performance counters. When it is not defined, the counter ports read zero.
// The reset input is asynchronous and active-low. The outputs are Mealy and
// are forced to zero while reset is held low.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT  = 255,
    parameter int LU_STALL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rsW_EX,
    input  logic        RegWEn_EX,
    input  logic [1:0]  WBSel_EX,
    input  logic        MemAcc_MEM,
    input  logic        branch_taken_EX,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        stall_PC,
    output logic        stall_IFID,
    output logic        stall_IDEX,
    output logic        stall_EXMEM,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic        bubble_MEMWB,
    output logic        timeout_err,
    output logic [1:0]  state,
    output logic [31:0] mem_stall_cnt,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int LCW = (LU_STALL > 1) ? $clog2(LU_STALL) : 1;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);
    localparam logic [LCW-1:0] LU_LAST    = LCW'(LU_STALL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEM_WAIT = 2'b01,
        LOAD_USE = 2'b10,
        ERR      = 2'b11
    } state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [LCW-1:0] lu_cnt_reg, lu_cnt_next;

    logic lu;
    logic mem_miss;
    logic mem_stall;
    logic br_flush;
    logic lu_hold;

    // A load in EX whose destination is read by the instruction in ID.
    // Register x0 is never a real dependency.
    assign lu = (WBSel_EX == 2'b01) && RegWEn_EX && (rsW_EX != 5'd0) &&
                ((rs1_used_ID && (rs1_ID == rsW_EX)) ||
                 (rs2_used_ID && (rs2_ID == rsW_EX)));

    // A memory access that is not completed this cycle.
    assign mem_miss = MemAcc_MEM && !dmem_ready;

    // State register together with the wait and load-use cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            lu_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            lu_cnt_reg   <= lu_cnt_next;
        end
    end

    // Next-state logic. LOAD_USE falls back to the IDLE rules whenever a miss
    // or a taken branch shows up, so both states share one decision tree.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        lu_cnt_next   = lu_cnt_reg;
        case (state_reg)
            IDLE, LOAD_USE: begin
                if (mem_miss) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WCW'(1);
                end else if (branch_taken_EX) begin
                    state_next = IDLE;
                end else if (state_reg == LOAD_USE) begin
                    if (lu_cnt_reg == LU_LAST) begin
                        state_next = IDLE;
                    end else begin
                        lu_cnt_next = lu_cnt_reg + LCW'(1);
                    end
                end else if (lu && (LU_STALL > 1)) begin
                    state_next  = LOAD_USE;
                    lu_cnt_next = LCW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = IDLE;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    state_next = ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                end
            end
            default: state_next = ERR;
        endcase
    end

    // Output decode into three causes (memory stall, branch flush and
    // load-use hold). Everything is zero while reset is held low.
    always_comb begin
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        br_flush    = 1'b0;
        lu_hold     = 1'b0;
        timeout_err = 1'b0;
        if (reset) begin
            case (state_reg)
                IDLE, LOAD_USE: begin
                    dmem_req = MemAcc_MEM;
                    if (mem_miss) begin
                        mem_stall = 1'b1;
                    end else if (branch_taken_EX) begin
                        br_flush = 1'b1;
                    end else if ((state_reg == LOAD_USE) || lu) begin
                        lu_hold = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req  = 1'b1;
                    mem_stall = !dmem_ready;
                end
                default: begin
                    mem_stall   = 1'b1;
                    timeout_err = 1'b1;
                end
            endcase
        end
    end

    assign stall_PC     = mem_stall | lu_hold;
    assign stall_IFID   = mem_stall | lu_hold;
    assign stall_IDEX   = mem_stall;
    assign stall_EXMEM  = mem_stall;
    assign flush_IFID   = br_flush;
    assign flush_IDEX   = br_flush | lu_hold;
    assign bubble_MEMWB = mem_stall;
    assign state        = state_reg;

`ifdef HAZARD_PERF_CNT_EN
    // Increment sources: bit 0 is the memory stall, bit 1 is the load-use
    // stall and bit 2 is the flush.
    logic [2:0] perf_inc;
    assign perf_inc = {br_flush, lu_hold, mem_stall};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        // Saturating event counter.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign mem_stall_cnt = g_perf[0].cnt_reg;
    assign lu_stall_cnt  = g_perf[1].cnt_reg;
    assign flush_cnt     = g_perf[2].cnt_reg;
`else
    assign mem_stall_cnt = 32'd0;
    assign lu_stall_cnt  = 32'd0;
    assign flush_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Two instances share the same stimulus:
// instance A uses TIMEOUT=4 and LU_STALL=1; instance B uses TIMEOUT=7 and
// LU_STALL=3. Expected behaviour comes from a cycle model that tracks the
// wait length, the remaining load-use hold cycles and a sticky error flag.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TO_A = 4, LUS_A = 1, TO_B = 7, LUS_B = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    // Control vector bit order:
    // {req, sPC, sIFID, sIDEX, sEXMEM, fIFID, fIDEX, bubble, terr}
    localparam logic [8:0] V_STALL = 9'b0_1111_0010;
    localparam logic [8:0] V_ERR   = 9'b0_1111_0011;
    localparam logic [8:0] V_FLUSH = 9'b0_0000_1100;
    localparam logic [8:0] V_LU    = 9'b0_1100_0100;
    localparam logic [22:0] IDLE_V = 23'd0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rs1_ID, rs2_ID, rsW_EX;
    logic rs1_used_ID, rs2_used_ID, RegWEn_EX;
    logic [1:0] WBSel_EX;
    logic MemAcc_MEM, branch_taken_EX, dmem_ready;

    wire [8:0]  ctl_a, ctl_b;
    wire [1:0]  st_a, st_b;
    wire [31:0] mc_a, lc_a, fc_a, mc_b, lc_b, fc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO_A), .LU_STALL(LUS_A)) u_a (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rsW_EX(rsW_EX), .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .MemAcc_MEM(MemAcc_MEM),
        .branch_taken_EX(branch_taken_EX), .dmem_ready(dmem_ready),
        .dmem_req(ctl_a[8]), .stall_PC(ctl_a[7]), .stall_IFID(ctl_a[6]), .stall_IDEX(ctl_a[5]),
        .stall_EXMEM(ctl_a[4]), .flush_IFID(ctl_a[3]), .flush_IDEX(ctl_a[2]),
        .bubble_MEMWB(ctl_a[1]), .timeout_err(ctl_a[0]), .state(st_a),
        .mem_stall_cnt(mc_a), .lu_stall_cnt(lc_a), .flush_cnt(fc_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(TO_B), .LU_STALL(LUS_B)) u_b (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rsW_EX(rsW_EX), .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .MemAcc_MEM(MemAcc_MEM),
        .branch_taken_EX(branch_taken_EX), .dmem_ready(dmem_ready),
        .dmem_req(ctl_b[8]), .stall_PC(ctl_b[7]), .stall_IFID(ctl_b[6]), .stall_IDEX(ctl_b[5]),
        .stall_EXMEM(ctl_b[4]), .flush_IFID(ctl_b[3]), .flush_IDEX(ctl_b[2]),
        .bubble_MEMWB(ctl_b[1]), .timeout_err(ctl_b[0]), .state(st_b),
        .mem_stall_cnt(mc_b), .lu_stall_cnt(lc_b), .flush_cnt(fc_b)
    );

    // ---------------- reference model ----------------
    bit m_err[2], m_wait[2], n_err[2], n_wait[2], e_lu[2];
    int m_run[2], m_left[2], n_run[2], n_left[2];
    longint m_cm[2], m_cl[2], m_cf[2];
    logic [8:0] e_ctl[2];
    logic [1:0] e_st[2];

    function automatic int to_of(int i);
        return (i == 0) ? TO_A : TO_B;
    endfunction

    function automatic int lus_of(int i);
        return (i == 0) ? LUS_A : LUS_B;
    endfunction

    function automatic bit lu_now();
        return (WBSel_EX == 2'b01) && RegWEn_EX && (rsW_EX != 5'd0) &&
               ((rs1_used_ID && rs1_ID == rsW_EX) || (rs2_used_ID && rs2_ID == rsW_EX));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0; m_wait[i] = 0; m_run[i] = 0; m_left[i] = 0;
            m_cm[i] = 0; m_cl[i] = 0; m_cf[i] = 0;
        end
    endfunction

    function automatic void model_eval();
        for (int i = 0; i < 2; i++) begin
            n_err[i] = m_err[i]; n_wait[i] = m_wait[i];
            n_run[i] = m_run[i]; n_left[i] = m_left[i];
            e_ctl[i] = 9'd0; e_lu[i] = 0;
            e_st[i] = m_err[i] ? 2'b11 : m_wait[i] ? 2'b01 : (m_left[i] > 0) ? 2'b10 : 2'b00;
            if (!reset) begin
                e_st[i] = 2'b00;
            end else if (m_err[i]) begin
                e_ctl[i] = V_ERR;
            end else if (m_wait[i]) begin
                e_ctl[i][8] = 1'b1;
                if (dmem_ready) begin
                    n_wait[i] = 0; n_run[i] = 0;
                end else begin
                    e_ctl[i] = e_ctl[i] | V_STALL;
                    n_run[i] = m_run[i] + 1;
                    // The error fires once the miss run outlasts TIMEOUT wait cycles.
                    if (n_run[i] == to_of(i) + 1) begin
                        n_err[i] = 1; n_wait[i] = 0;
                    end
                end
            end else begin
                e_ctl[i][8] = MemAcc_MEM;
                if (MemAcc_MEM && !dmem_ready) begin
                    e_ctl[i] = e_ctl[i] | V_STALL;
                    n_wait[i] = 1; n_run[i] = 1; n_left[i] = 0;
                end else if (branch_taken_EX) begin
                    e_ctl[i] = e_ctl[i] | V_FLUSH;
                    n_left[i] = 0;
                end else if (m_left[i] > 0) begin
                    e_ctl[i] = e_ctl[i] | V_LU; e_lu[i] = 1;
                    n_left[i] = m_left[i] - 1;
                end else if (lu_now()) begin
                    e_ctl[i] = e_ctl[i] | V_LU; e_lu[i] = 1;
                    n_left[i] = lus_of(i) - 1;
                end
            end
        end
    endfunction

    function automatic void model_commit();
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_err[i] = n_err[i]; m_wait[i] = n_wait[i];
                m_run[i] = n_run[i]; m_left[i] = n_left[i];
                if (e_ctl[i][4] && m_cm[i] < 64'hFFFF_FFFF) m_cm[i]++;
                if (e_lu[i] && m_cl[i] < 64'hFFFF_FFFF) m_cl[i]++;
                if (e_ctl[i][3] && m_cf[i] < 64'hFFFF_FFFF) m_cf[i]++;
            end
        end
    endfunction

    function automatic logic [31:0] exp_cnt(longint v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [10:0] act(int i);
        return (i == 0) ? {ctl_a, st_a} : {ctl_b, st_b};
    endfunction

    function automatic logic [95:0] act_cnt(int i);
        return (i == 0) ? {mc_a, lc_a, fc_a} : {mc_b, lc_b, fc_b};
    endfunction

    function automatic logic [22:0] mk(bit mem, bit rdy, bit br, logic [1:0] wb, bit we,
                                       logic [4:0] rd, logic [4:0] r1, bit u1,
                                       logic [4:0] r2, bit u2);
        return {mem, rdy, br, wb, we, rd, r1, u1, r2, u2};
    endfunction

    task automatic apply(logic [22:0] v);
        {MemAcc_MEM, dmem_ready, branch_taken_EX, WBSel_EX, RegWEn_EX, rsW_EX,
         rs1_ID, rs1_used_ID, rs2_ID, rs2_used_ID} = v;
    endtask

    // Called at negedge+1: advance through one active edge and return at the next negedge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        apply(mk(1, 0, 0, 2'b01, 1, 5'd5, 5'd5, 1, 5'd5, 1));
        for (int k = 0; k < 2; k++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({act(i), act_cnt(i)} !== 107'd0) begin
                    errors++;
                    $display("FAIL reset_hold inst=%0d got=%h want=0", i, {act(i), act_cnt(i)});
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        model_eval();
        checks++;
        if (act(0) !== {9'b1_1111_0010, 2'b00}) begin
            errors++;
            $display("FAIL reset_release ctl/st got=%b want=%b", act(0), {9'b1_1111_0010, 2'b00});
        end
        tick();
        #1;
        checks++;
        if (st_a !== 2'b01 || st_b !== 2'b01) begin
            errors++;
            $display("FAIL reset_to_memwait state a=%b b=%b want=01", st_a, st_b);
        end
        apply(mk(1, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        tick();
        apply(IDLE_V);
        tick();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_load_use();
        logic [22:0] q[$];
        int b_stalls = 0;
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd5, 5'd3, 1, 5'd5, 1));   // rs2 hit on x5
        q.push_back(IDLE_V); q.push_back(IDLE_V); q.push_back(IDLE_V);
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd0, 5'd0, 1, 5'd0, 1));   // x0 never hazards
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd7, 5'd7, 0, 5'd1, 1));   // rs1 unused
        q.push_back(mk(0, 1, 0, 2'b10, 1, 5'd7, 5'd7, 1, 5'd1, 1));   // not a load
        q.push_back(mk(0, 1, 0, 2'b01, 0, 5'd7, 5'd7, 1, 5'd1, 1));   // no write
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd9, 5'd9, 1, 5'd2, 0));   // rs1 hit on x9
        q.push_back(IDLE_V); q.push_back(IDLE_V); q.push_back(IDLE_V);
        foreach (q[s]) begin
            apply(q[s]);
            #1;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act(i) !== {e_ctl[i], e_st[i]}) begin
                    errors++;
                    $display("FAIL load_use step=%0d inst=%0d got=%b want=%b", s, i, act(i), {e_ctl[i], e_st[i]});
                end
            end
            if (s == 0 || s == 8) begin
                checks++;
                if (ctl_a !== V_LU) begin
                    errors++;
                    $display("FAIL lu_stall_a step=%0d got=%b want=%b", s, ctl_a, V_LU);
                end
            end
            if (s == 1 || (s >= 4 && s <= 7)) begin
                checks++;
                if (ctl_a !== 9'd0) begin
                    errors++;
                    $display("FAIL lu_none_a step=%0d got=%b want=0", s, ctl_a);
                end
            end
            if (s <= 3 && ctl_b[7]) b_stalls++;
            tick();
        end
        checks++;
        if (b_stalls != LUS_B) begin
            errors++;
            $display("FAIL lu_len_b got=%0d want=%0d", b_stalls, LUS_B);
        end
        $display("test_load_use done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mem_wait();
        logic [22:0] q[$];
        int a_stalls = 0;
        for (int k = 0; k < 3; k++) q.push_back(mk(1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        q.push_back(mk(1, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        q.push_back(mk(1, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));   // zero-wait hit
        q.push_back(IDLE_V);
        foreach (q[s]) begin
            apply(q[s]);
            #1;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act(i) !== {e_ctl[i], e_st[i]}) begin
                    errors++;
                    $display("FAIL mem_wait step=%0d inst=%0d got=%b want=%b", s, i, act(i), {e_ctl[i], e_st[i]});
                end
            end
            if (s <= 3 && ctl_a[4]) a_stalls++;
            if (s == 3 || s == 4) begin
                checks++;
                if (ctl_a !== 9'b1_0000_0000) begin
                    errors++;
                    $display("FAIL mem_ready step=%0d got=%b want=100000000", s, ctl_a);
                end
            end
            if (s == 4) begin
                checks++;
                if (st_a !== 2'b00) begin
                    errors++;
                    $display("FAIL mem_back_idle got=%b want=00", st_a);
                end
            end
            tick();
        end
        checks++;
        if (a_stalls != 3) begin
            errors++;
            $display("FAIL mem_stall_len got=%0d want=3", a_stalls);
        end
        $display("test_mem_wait done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_branch();
        logic [22:0] q[$];
        q.push_back(mk(0, 1, 1, 2'b01, 1, 5'd4, 5'd4, 1, 5'd0, 0));   // branch + lu
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd6, 5'd0, 0, 5'd6, 1));   // lu
        q.push_back(mk(0, 1, 1, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));   // branch during B hold
        q.push_back(IDLE_V);
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd6, 5'd6, 1, 5'd0, 0));   // lu
        q.push_back(mk(1, 0, 0, 2'b01, 1, 5'd6, 5'd6, 1, 5'd0, 0));   // miss during B hold
        q.push_back(mk(1, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        q.push_back(IDLE_V);
        q.push_back(mk(1, 1, 1, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));   // hit + branch
        q.push_back(IDLE_V);
        foreach (q[s]) begin
            apply(q[s]);
            #1;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act(i) !== {e_ctl[i], e_st[i]}) begin
                    errors++;
                    $display("FAIL branch step=%0d inst=%0d got=%b want=%b", s, i, act(i), {e_ctl[i], e_st[i]});
                end
            end
            if (s == 0 || s == 2) begin
                checks++;
                if (ctl_b !== V_FLUSH) begin
                    errors++;
                    $display("FAIL branch_wins step=%0d got=%b want=%b", s, ctl_b, V_FLUSH);
                end
            end
            if (s == 3 || s == 6) begin
                checks++;
                if (st_b !== ((s == 3) ? 2'b00 : 2'b01)) begin
                    errors++;
                    $display("FAIL lu_escape step=%0d state_b got=%b", s, st_b);
                end
            end
            tick();
        end
        $display("test_branch done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_timeout();
        int a_wait = 0, b_wait = 0;
        apply(mk(1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        for (int s = 0; s < 15; s++) begin
            if (s == 12) apply(mk(0, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
            #1;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act(i) !== {e_ctl[i], e_st[i]}) begin
                    errors++;
                    $display("FAIL timeout step=%0d inst=%0d got=%b want=%b", s, i, act(i), {e_ctl[i], e_st[i]});
                end
            end
            if (st_a == 2'b01) a_wait++;
            if (st_b == 2'b01) b_wait++;
            if (s >= 12) begin
                checks++;
                if ({ctl_a, st_a} !== {V_ERR, 2'b11}) begin
                    errors++;
                    $display("FAIL err_sticky step=%0d got=%b want=%b", s, {ctl_a, st_a}, {V_ERR, 2'b11});
                end
            end
            tick();
        end
        checks++;
        if (a_wait != TO_A || b_wait != TO_B) begin
            errors++;
            $display("FAIL wait_len a=%0d b=%0d want %0d/%0d", a_wait, b_wait, TO_A, TO_B);
        end
        // Clear the error, enter MEM_WAIT, then pull reset in the middle of the wait.
        reset = 1'b0; model_reset();
        tick();
        reset = 1'b1;
        apply(mk(1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        tick();
        #1;
        checks++;
        if (ctl_a[8] !== 1'b1 || ctl_b[8] !== 1'b1 || st_a !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset_req a=%b b=%b st=%b want 1/1/01", ctl_a[8], ctl_b[8], st_a);
        end
        reset = 1'b0; model_reset();
        #1;
        checks++;
        if ({ctl_a, st_a, ctl_b, st_b} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset got=%b want=0", {ctl_a, st_a, ctl_b, st_b});
        end
        tick();
        reset = 1'b1;
        apply(IDLE_V);
        tick();
        $display("test_timeout done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_perf();
        logic [22:0] q[$];
        reset = 1'b0; model_reset();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) q.push_back(mk(1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        q.push_back(mk(1, 1, 0, 2'b00, 0, 5'd0, 5'd0, 0, 5'd0, 0));
        q.push_back(mk(0, 1, 0, 2'b01, 1, 5'd5, 5'd5, 1, 5'd0, 0));
        for (int k = 0; k < 3; k++) q.push_back(IDLE_V);
        foreach (q[s]) begin
            apply(q[s]);
            #1;
            model_eval();
            tick();
        end
        #1;
        checks++;
        if ({mc_a, lc_a, fc_a} !== {exp_cnt(3), exp_cnt(1), exp_cnt(0)}) begin
            errors++;
            $display("FAIL perf_a got=%0d/%0d/%0d want=%0d/%0d/0", mc_a, lc_a, fc_a, exp_cnt(3), exp_cnt(1));
        end
        checks++;
        if ({mc_b, lc_b, fc_b} !== {exp_cnt(3), exp_cnt(3), exp_cnt(0)}) begin
            errors++;
            $display("FAIL perf_b got=%0d/%0d/%0d want=%0d/%0d/0", mc_b, lc_b, fc_b, exp_cnt(3), exp_cnt(3));
        end
        $display("test_perf done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 30) begin
                reset = 1'b0; model_reset();
            end else begin
                reset = 1'b1;
            end
            MemAcc_MEM      = ($urandom_range(3) == 0);
            dmem_ready      = ($urandom_range(2) != 0);
            branch_taken_EX = ($urandom_range(7) == 0);
            WBSel_EX        = ($urandom_range(2) == 0) ? 2'(($urandom_range(3))) : 2'b01;
            RegWEn_EX       = ($urandom_range(4) != 0);
            rsW_EX          = 5'($urandom_range(3));
            rs1_ID          = 5'($urandom_range(3));
            rs2_ID          = 5'($urandom_range(3));
            rs1_used_ID     = 1'($urandom_range(1));
            rs2_used_ID     = 1'($urandom_range(1));
            #1;
            model_eval();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act(i) !== {e_ctl[i], e_st[i]}) begin
                    errors++;
                    $display("FAIL random cyc=%0d inst=%0d got=%b want=%b", c, i, act(i), {e_ctl[i], e_st[i]});
                end
                checks++;
                if (act_cnt(i) !== {exp_cnt(m_cm[i]), exp_cnt(m_cl[i]), exp_cnt(m_cf[i])}) begin
                    errors++;
                    $display("FAIL random_cnt cyc=%0d inst=%0d got=%h want=%h", c, i, act_cnt(i),
                             {exp_cnt(m_cm[i]), exp_cnt(m_cl[i]), exp_cnt(m_cf[i])});
                end
            end
            tick();
        end
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        apply(IDLE_V);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_perf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
